server_traffic_gen: RTL and testbench

Parametrised per-server traffic source and latency monitor for the rack-scale ToR testbench. It sits on one server port of a ToR model. The TX side emits fixed-length Ethernet-like frames to rotating destination ToRs and pseudo-random destination servers, with full AXI-Stream backpressure. The RX side checks incoming frames and, when compiled in, measures end-to-end latency from the embedded timestamp.

---
 rtl/server_traffic_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_server_traffic_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/server_traffic_gen.sv
// server_traffic_gen: per-server traffic source and latency monitor.
// TX emits fixed-length frames to rotating destination ToRs and LFSR-picked
// destination servers; RX counts good/bad frames and, when the macro
// SERVER_LATENCY_STAT_EN is defined, tracks last/min/max end-to-end latency
// from the timestamp carried in beat 2.
module server_traffic_gen #(
  parameter int          P_TOR_NUM    = 8,
  parameter int          P_SERVER_NUM = 2,
  parameter int          P_MY_TOR     = 0,
  parameter int          P_MY_PORT    = 1,
  parameter logic [31:0] P_MAC_HEAD   = 32'h8DBC5C4A,
  parameter int          P_PKT_LEN    = 128,
  parameter int          P_GAP_CYCLE  = 294,
  parameter logic [15:0] P_SEED       = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sim_start,
  input  logic        i_sim_stop,
  input  logic [63:0] i_time_stamp,
  output logic        tx_axis_tvalid,
  output logic [63:0] tx_axis_tdata,
  output logic        tx_axis_tlast,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tuser,
  input  logic        tx_axis_tready,
  input  logic        rx_axis_tvalid,
  input  logic [63:0] rx_axis_tdata,
  input  logic        rx_axis_tlast,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tuser,
  output logic        rx_axis_tready,
  output logic [31:0] o_tx_pkt_cnt,
  output logic [31:0] o_rx_pkt_cnt,
  output logic [31:0] o_rx_err_cnt,
  output logic        o_lat_valid,
  output logic [63:0] o_lat_last,
  output logic [63:0] o_lat_min,
  output logic [63:0] o_lat_max
);

  localparam logic [7:0]  LP_TOR_LAST  = 8'(P_TOR_NUM - 1);
  localparam logic [7:0]  LP_MY_TOR    = 8'(P_MY_TOR);
  localparam logic [7:0]  LP_MY_PORT   = 8'(P_MY_PORT);
  localparam logic [7:0]  LP_SRV_MASK  = 8'(P_SERVER_NUM - 1);
  localparam logic [7:0]  LP_LOCAL_SRV = 8'((P_MY_PORT % P_SERVER_NUM) + 1);
  localparam logic [47:0] LP_SRC_MAC   = {P_MAC_HEAD, LP_MY_TOR, LP_MY_PORT};
  localparam logic [31:0] LP_LAST_BEAT = 32'(P_PKT_LEN - 1);
  localparam logic [31:0] LP_GAP_LAST  = (P_GAP_CYCLE > 0) ? 32'(P_GAP_CYCLE - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_RANDOM, S_DATA, S_GAP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_run;
  logic        r_rand_cyc;
  logic [15:0] r_lfsr;
  logic [7:0]  r_dst_tor;
  logic [7:0]  r_dst_srv;
  logic [31:0] r_beat;
  logic [31:0] r_gap_cnt;
  logic [15:0] r_seq;
  logic [63:0] r_ts;
  logic        r_ts_held;
  logic [31:0] r_tx_pkt_cnt;

  logic        w_tx_fire;
  logic        w_lfsr_fb;
  logic [7:0]  w_tor_step1;
  logic [7:0]  w_tor_step2;
  logic [7:0]  w_tor_adv;
  logic [47:0] w_dst_mac;

  assign tx_axis_tvalid = (r_state == S_DATA);
  assign tx_axis_tlast  = tx_axis_tvalid && (r_beat == LP_LAST_BEAT);
  assign tx_axis_tkeep  = 8'hFF;
  assign tx_axis_tuser  = 1'b0;
  assign w_tx_fire      = tx_axis_tvalid && tx_axis_tready;
  assign o_tx_pkt_cnt   = r_tx_pkt_cnt;

  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_tor_step1 = (r_dst_tor == LP_TOR_LAST) ? 8'd0 : r_dst_tor + 8'd1;
  assign w_tor_step2 = (w_tor_step1 == LP_TOR_LAST) ? 8'd0 : w_tor_step1 + 8'd1;
  // With a single server per ToR the own ToR has no other local target, so skip it.
  assign w_tor_adv   = ((P_SERVER_NUM == 1) && (w_tor_step1 == LP_MY_TOR)) ? w_tor_step2 : w_tor_step1;
  assign w_dst_mac   = {P_MAC_HEAD, r_dst_tor, r_dst_srv};

  // Beat payload; beat 2 shows the live timestamp on its first valid cycle, then the held copy.
  always_comb begin
    tx_axis_tdata = {48'd0, r_beat[15:0]};
    case (r_beat)
      32'd0:   tx_axis_tdata = {w_dst_mac, LP_SRC_MAC[47:32]};
      32'd1:   tx_axis_tdata = {LP_SRC_MAC[31:0], 16'h0800, r_seq};
      32'd2:   tx_axis_tdata = r_ts_held ? r_ts : i_time_stamp;
      default: tx_axis_tdata = {48'd0, r_beat[15:0]};
    endcase
  end

  // TX state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // TX next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (r_run) w_state_next = S_RANDOM;
      S_RANDOM: if (r_rand_cyc) w_state_next = S_DATA;
      S_DATA:   if (w_tx_fire && tx_axis_tlast) w_state_next = S_GAP;
      S_GAP:    if (r_gap_cnt >= LP_GAP_LAST) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Run flag; stop has priority over a simultaneous start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            r_run <= 1'b0;
    else if (i_sim_stop)  r_run <= 1'b0;
    else if (i_sim_start) r_run <= 1'b1;
  end

  // TX datapath: destination selection, beat/sequence counters, timestamp hold, gap timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rand_cyc   <= 1'b0;
      r_lfsr       <= P_SEED;
      r_dst_tor    <= LP_MY_TOR;
      r_dst_srv    <= 8'd0;
      r_beat       <= 32'd0;
      r_gap_cnt    <= 32'd0;
      r_seq        <= 16'd0;
      r_ts         <= 64'd0;
      r_ts_held    <= 1'b0;
      r_tx_pkt_cnt <= 32'd0;
    end else begin
      r_rand_cyc <= (r_state == S_RANDOM) && !r_rand_cyc;
      if (r_state == S_RANDOM && !r_rand_cyc) begin
        r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
        r_dst_tor <= w_tor_adv;
      end
      if (r_state == S_RANDOM && r_rand_cyc) begin
        if (r_dst_tor == LP_MY_TOR) r_dst_srv <= LP_LOCAL_SRV;
        else                        r_dst_srv <= (r_lfsr[7:0] & LP_SRV_MASK) + 8'd1;
      end
      if (tx_axis_tvalid && r_beat == 32'd2 && !r_ts_held) begin
        r_ts      <= i_time_stamp;
        r_ts_held <= 1'b1;
      end
      if (w_tx_fire) begin
        if (r_beat == 32'd2) r_ts_held <= 1'b0;
        if (tx_axis_tlast) begin
          r_beat <= 32'd0;
          r_seq  <= r_seq + 16'd1;
          if (r_tx_pkt_cnt != 32'hFFFF_FFFF) r_tx_pkt_cnt <= r_tx_pkt_cnt + 32'd1;
        end else begin
          r_beat <= r_beat + 32'd1;
        end
      end
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 32'd1;
      else                  r_gap_cnt <= 32'd0;
    end
  end

  // ---------------- RX side ----------------
  logic [31:0] r_rx_beat;
  logic        r_rx_b0_ok;
  logic [31:0] r_rx_pkt_cnt;
  logic [31:0] r_rx_err_cnt;
  logic        w_rx_fire;
  logic        w_b0_ok;
  logic        w_rx_good;
  logic        w_unused_rx;

  assign rx_axis_tready = 1'b1;
  assign w_rx_fire      = rx_axis_tvalid;
  assign w_b0_ok        = (r_rx_beat == 32'd0) ? (rx_axis_tdata[63:16] == LP_SRC_MAC) : r_rx_b0_ok;
  // Current beat index >= 2 at tlast means at least three beats.
  assign w_rx_good      = w_b0_ok && (r_rx_beat >= 32'd2) && !rx_axis_tuser;
  assign o_rx_pkt_cnt   = r_rx_pkt_cnt;
  assign o_rx_err_cnt   = r_rx_err_cnt;
  assign w_unused_rx    = ^{rx_axis_tkeep, rx_axis_tdata[15:0]};

  // RX frame checker and good/bad frame counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_beat    <= 32'd0;
      r_rx_b0_ok   <= 1'b0;
      r_rx_pkt_cnt <= 32'd0;
      r_rx_err_cnt <= 32'd0;
    end else if (w_rx_fire) begin
      if (r_rx_beat == 32'd0) r_rx_b0_ok <= w_b0_ok;
      if (rx_axis_tlast) begin
        r_rx_beat <= 32'd0;
        if (w_rx_good) begin
          if (r_rx_pkt_cnt != 32'hFFFF_FFFF) r_rx_pkt_cnt <= r_rx_pkt_cnt + 32'd1;
        end else begin
          if (r_rx_err_cnt != 32'hFFFF_FFFF) r_rx_err_cnt <= r_rx_err_cnt + 32'd1;
        end
      end else if (r_rx_beat != 32'hFFFF_FFFF) begin
        r_rx_beat <= r_rx_beat + 32'd1;
      end
    end
  end

`ifdef SERVER_LATENCY_STAT_EN
  logic [63:0] r_lat_pend;
  logic        r_lat_valid;
  logic [63:0] r_lat_last;
  logic [63:0] r_lat_min;
  logic [63:0] r_lat_max;
  logic [63:0] w_lat_now;
  logic [63:0] w_lat_sample;

  assign w_lat_now    = i_time_stamp - rx_axis_tdata;
  // A 3-beat frame ends on beat 2 itself, so take the sample directly in that case.
  assign w_lat_sample = (r_rx_beat == 32'd2) ? w_lat_now : r_lat_pend;
  assign o_lat_valid  = r_lat_valid;
  assign o_lat_last   = r_lat_last;
  assign o_lat_min    = r_lat_min;
  assign o_lat_max    = r_lat_max;

  // Latency capture on beat 2 and statistics commit at tlast of a good frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lat_pend  <= 64'd0;
      r_lat_valid <= 1'b0;
      r_lat_last  <= 64'd0;
      r_lat_min   <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_lat_max   <= 64'd0;
    end else begin
      r_lat_valid <= 1'b0;
      if (w_rx_fire && r_rx_beat == 32'd2) r_lat_pend <= w_lat_now;
      if (w_rx_fire && rx_axis_tlast && w_rx_good) begin
        r_lat_valid <= 1'b1;
        r_lat_last  <= w_lat_sample;
        if (w_lat_sample < r_lat_min) r_lat_min <= w_lat_sample;
        if (w_lat_sample > r_lat_max) r_lat_max <= w_lat_sample;
      end
    end
  end
`else
  assign o_lat_valid = 1'b0;
  assign o_lat_last  = 64'd0;
  assign o_lat_min   = 64'hFFFF_FFFF_FFFF_FFFF;
  assign o_lat_max   = 64'd0;
`endif

endmodule

// File: tb/tb_server_traffic_gen.sv
// Directed testbench for server_traffic_gen at default parameters.
module tb_server_traffic_gen;

  localparam int          PKT_LEN = 128;
  localparam logic [47:0] SRC_MAC = {32'h8DBC5C4A, 8'd0, 8'd1};

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_sim_start = 1'b0;
  logic        i_sim_stop = 1'b0;
  logic [63:0] time_stamp = 64'd1000;
  logic        tx_axis_tvalid;
  logic [63:0] tx_axis_tdata;
  logic        tx_axis_tlast;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tuser;
  logic        tx_axis_tready = 1'b1;
  logic        rx_axis_tvalid;
  logic [63:0] rx_axis_tdata;
  logic        rx_axis_tlast;
  logic        rx_axis_tuser;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_axis_tready;
  logic [31:0] o_tx_pkt_cnt, o_rx_pkt_cnt, o_rx_err_cnt;
  logic        o_lat_valid;
  logic [63:0] o_lat_last, o_lat_min, o_lat_max;

  // manual RX drive vs TX loopback through a 100-cycle delay line
  logic        loop_en = 1'b0;
  logic        m_valid = 1'b0, m_last = 1'b0, m_user = 1'b0;
  logic [63:0] m_data = 64'd0;
  logic [65:0] dl [0:99];
  logic        tx_first = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] exp_lfsr = 16'hACE1;
  int lat_pulses = 0;
  logic [63:0] seen_min = '1, seen_max = '0;

  always #5 clk = ~clk;
  always @(posedge clk) time_stamp <= time_stamp + 64'd1;

  assign rx_axis_tvalid = loop_en ? dl[99][65] : m_valid;
  assign rx_axis_tlast  = loop_en ? dl[99][64] : m_last;
  assign rx_axis_tdata  = loop_en ? dl[99][63:0] : m_data;
  assign rx_axis_tuser  = loop_en ? 1'b0 : m_user;
  assign rx_axis_tkeep  = 8'hFF;

  // Delay line; the first beat of each frame is re-addressed to this server.
  always @(posedge clk) begin
    if (tx_axis_tvalid && tx_axis_tready) begin
      dl[0]    <= {1'b1, tx_axis_tlast, (tx_first ? {SRC_MAC, tx_axis_tdata[15:0]} : tx_axis_tdata)};
      tx_first <= tx_axis_tlast;
    end else begin
      dl[0] <= 66'd0;
    end
    for (int i = 1; i < 100; i++) dl[i] <= dl[i-1];
  end

  always @(negedge clk) begin
    if (o_lat_valid === 1'b1) begin
      lat_pulses++;
      if (o_lat_last < seen_min) seen_min = o_lat_last;
      if (o_lat_last > seen_max) seen_max = o_lat_last;
    end
  end

  server_traffic_gen dut (
    .i_clk(clk), .i_rst(i_rst), .i_sim_start(i_sim_start), .i_sim_stop(i_sim_stop),
    .i_time_stamp(time_stamp),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tdata(tx_axis_tdata), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tuser(tx_axis_tuser), .tx_axis_tready(tx_axis_tready),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tuser(rx_axis_tuser), .rx_axis_tready(rx_axis_tready),
    .o_tx_pkt_cnt(o_tx_pkt_cnt), .o_rx_pkt_cnt(o_rx_pkt_cnt), .o_rx_err_cnt(o_rx_err_cnt),
    .o_lat_valid(o_lat_valid), .o_lat_last(o_lat_last), .o_lat_min(o_lat_min), .o_lat_max(o_lat_max)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic pulse(input logic start, input logic stop);
    @(negedge clk);
    i_sim_start = start;
    i_sim_stop  = stop;
    @(posedge clk); #1;
    i_sim_start = 1'b0;
    i_sim_stop  = 1'b0;
  endtask

  // Collects one TX frame; counts protocol/content errors in errs.
  task automatic collect_frame(input int stall_mode, input int stop_beat,
                               output logic [7:0] tor, output logic [7:0] srv,
                               output logic [15:0] seq, output int len, output int errs);
    int b, cyc, phase;
    bit prev_stall, b2_seen, stop_done;
    logic [63:0] prev_data;
    logic prev_last;
    b = 0; cyc = 0; phase = 0; prev_stall = 0; b2_seen = 0; stop_done = 0;
    errs = 0; tor = 0; srv = 0; seq = 0; prev_data = 0; prev_last = 0;
    while (b < PKT_LEN && cyc < 3000) begin
      i_sim_stop = 1'b0;
      if (stop_beat >= 0 && b == stop_beat && !stop_done && tx_axis_tvalid) begin
        i_sim_stop = 1'b1;
        stop_done = 1;
      end
      tx_axis_tready = (stall_mode == 0) ? 1'b1 : (phase == 0);
      phase = (phase == 2) ? 0 : phase + 1;
      if (tx_axis_tvalid) begin
        if (prev_stall && (tx_axis_tdata !== prev_data || tx_axis_tlast !== prev_last)) errs++;
        if (tx_axis_tkeep !== 8'hFF || tx_axis_tuser !== 1'b0) errs++;
        if (tx_axis_tlast !== (b == PKT_LEN - 1)) errs++;
        case (b)
          0: begin
            if (tx_axis_tdata[63:32] !== SRC_MAC[47:16] || tx_axis_tdata[15:0] !== SRC_MAC[47:32]) errs++;
            tor = tx_axis_tdata[23:16];
            srv = tx_axis_tdata[31:24] == 8'h00 ? tx_axis_tdata[15:8] : tx_axis_tdata[15:8];
            tor = tx_axis_tdata[31:24];
            srv = tx_axis_tdata[23:16];
          end
          1: begin
            if (tx_axis_tdata[63:32] !== SRC_MAC[31:0] || tx_axis_tdata[31:16] !== 16'h0800) errs++;
            seq = tx_axis_tdata[15:0];
          end
          2: if (!b2_seen) begin
            b2_seen = 1;
            if (tx_axis_tdata !== time_stamp) errs++;
          end
          default: if (tx_axis_tdata !== {48'd0, 16'(b)}) errs++;
        endcase
        if (tx_axis_tready) begin
          b++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_data = tx_axis_tdata;
          prev_last = tx_axis_tlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_sim_stop = 1'b0;
    tx_axis_tready = 1'b1;
    len = b;
    $display("frame tor=%0d srv=%0d seq=%0d len=%0d errs=%0d", tor, srv, seq, len, errs);
  endtask

  task automatic send_rx_frame(input logic [47:0] dst, input int nbeats, input logic bad_user,
                               input logic [63:0] lat);
    for (int b = 0; b < nbeats; b++) begin
      m_valid = 1'b1;
      m_last  = (b == nbeats - 1);
      m_user  = (b == nbeats - 1) ? bad_user : 1'b0;
      if (b == 0)      m_data = {dst, 16'h0000};
      else if (b == 2) m_data = time_stamp - lat;
      else             m_data = 64'(b);
      @(posedge clk); #1;
    end
    m_valid = 1'b0; m_last = 1'b0; m_user = 1'b0;
    $display("rx frame dst=%h beats=%0d tuser=%0d", dst, nbeats, bad_user);
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); i_rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (tx_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %0d want 0", tx_axis_tvalid); else n_pass++;
    n_checks++; if (rx_axis_tready !== 1'b1) $display("FAIL reset_rx_tready got %0d want 1", rx_axis_tready); else n_pass++;
    n_checks++; if (o_tx_pkt_cnt !== 0 || o_rx_pkt_cnt !== 0 || o_rx_err_cnt !== 0)
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", o_tx_pkt_cnt, o_rx_pkt_cnt, o_rx_err_cnt); else n_pass++;
    n_checks++; if (o_lat_min !== 64'hFFFF_FFFF_FFFF_FFFF || o_lat_max !== 0 || o_lat_valid !== 0)
      $display("FAIL reset_lat got min=%h max=%h v=%0d", o_lat_min, o_lat_max, o_lat_valid); else n_pass++;
  endtask

  task automatic test_start_latency;
    logic [3:0] v;
    pulse(1'b1, 1'b0);
    v[0] = tx_axis_tvalid;
    for (int i = 1; i < 4; i++) begin @(posedge clk); #1; v[i] = tx_axis_tvalid; end
    $display("start: tvalid after edges k..k+3 = %b", v);
    n_checks++; if (v !== 4'b1000) $display("FAIL start_latency got %b want 1000", v); else n_pass++;
  endtask

  task automatic test_first_frame;
    logic [7:0] tor, srv; logic [15:0] seq; int len, errs;
    collect_frame(0, -1, tor, srv, seq, len, errs);
    exp_lfsr = lfsr_step(exp_lfsr);
    n_checks++; if (len !== PKT_LEN) $display("FAIL first_len got %0d want %0d", len, PKT_LEN); else n_pass++;
    n_checks++; if (errs !== 0) $display("FAIL first_beats got %0d errors want 0", errs); else n_pass++;
    n_checks++; if (seq !== 16'd0) $display("FAIL first_seq got %0d want 0", seq); else n_pass++;
    n_checks++; if (tor !== 8'd1) $display("FAIL first_tor got %0d want 1", tor); else n_pass++;
    n_checks++; if (srv !== {7'd0, exp_lfsr[0]} + 8'd1) $display("FAIL first_srv got %0d want %0d", srv, exp_lfsr[0] + 1); else n_pass++;
    n_checks++; if (o_tx_pkt_cnt !== 32'd1) $display("FAIL first_txcnt got %0d want 1", o_tx_pkt_cnt); else n_pass++;
  endtask

  task automatic test_gap;
    int n = 0;
    while (!tx_axis_tvalid && n < 400) begin @(posedge clk); #1; n++; end
    $display("gap: next tvalid %0d cycles after tlast", n);
    n_checks++; if (n !== 297) $display("FAIL gap_cycles got %0d want 297", n); else n_pass++;
  endtask

  task automatic test_tor_sequence;
    logic [7:0] tor, srv, etor, esrv; logic [15:0] seq; int len, errs;
    for (int i = 1; i < 16; i++) begin
      collect_frame(0, -1, tor, srv, seq, len, errs);
      exp_lfsr = lfsr_step(exp_lfsr);
      etor = 8'((i + 1) % 8);
      esrv = (etor == 0) ? 8'd2 : {7'd0, exp_lfsr[0]} + 8'd1;
      n_checks++; if (len !== PKT_LEN || errs !== 0) $display("FAIL seq_frame%0d len=%0d errs=%0d want %0d/0", i, len, errs, PKT_LEN); else n_pass++;
      n_checks++; if (tor !== etor) $display("FAIL seq_tor%0d got %0d want %0d", i, tor, etor); else n_pass++;
      n_checks++; if (srv !== esrv) $display("FAIL seq_srv%0d got %0d want %0d", i, srv, esrv); else n_pass++;
      n_checks++; if (seq !== 16'(i)) $display("FAIL seq_num%0d got %0d want %0d", i, seq, i); else n_pass++;
    end
    n_checks++; if (o_tx_pkt_cnt !== 32'd16) $display("FAIL seq_txcnt got %0d want 16", o_tx_pkt_cnt); else n_pass++;
  endtask

  task automatic test_stall;
    logic [7:0] tor, srv; logic [15:0] seq; int len, errs;
    collect_frame(1, -1, tor, srv, seq, len, errs);
    exp_lfsr = lfsr_step(exp_lfsr);
    n_checks++; if (len !== PKT_LEN || errs !== 0) $display("FAIL stall_frame len=%0d errs=%0d want %0d/0", len, errs, PKT_LEN); else n_pass++;
    n_checks++; if (seq !== 16'd16 || tor !== 8'd1) $display("FAIL stall_hdr seq=%0d tor=%0d want 16/1", seq, tor); else n_pass++;
    n_checks++; if (o_tx_pkt_cnt !== 32'd17) $display("FAIL stall_txcnt got %0d want 17", o_tx_pkt_cnt); else n_pass++;
  endtask

  task automatic test_stop_mid_frame;
    logic [7:0] tor, srv; logic [15:0] seq; int len, errs, extra;
    collect_frame(0, 10, tor, srv, seq, len, errs);
    n_checks++; if (len !== PKT_LEN || errs !== 0) $display("FAIL stop_frame len=%0d errs=%0d want %0d/0", len, errs, PKT_LEN); else n_pass++;
    extra = 0;
    repeat (500) begin @(posedge clk); #1; if (tx_axis_tvalid) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL stop_no_more got %0d valid cycles want 0", extra); else n_pass++;
    n_checks++; if (o_tx_pkt_cnt !== 32'd18) $display("FAIL stop_txcnt got %0d want 18", o_tx_pkt_cnt); else n_pass++;
  endtask

  task automatic test_same_cycle;
    int extra = 0;
    pulse(1'b1, 1'b1);
    repeat (40) begin @(posedge clk); #1; if (tx_axis_tvalid) extra++; end
    $display("start+stop same cycle: %0d valid cycles", extra);
    n_checks++; if (extra !== 0) $display("FAIL same_cycle got %0d valid cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_rx_errors;
    send_rx_frame(SRC_MAC ^ 48'h1, 4, 1'b0, 64'd7);
    send_rx_frame(SRC_MAC, 2, 1'b0, 64'd7);
    send_rx_frame(SRC_MAC, 4, 1'b1, 64'd7);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (o_rx_err_cnt !== 32'd3) $display("FAIL rx_err_cnt got %0d want 3", o_rx_err_cnt); else n_pass++;
    n_checks++; if (o_rx_pkt_cnt !== 32'd0) $display("FAIL rx_err_pkt got %0d want 0", o_rx_pkt_cnt); else n_pass++;
    n_checks++; if (lat_pulses !== 0) $display("FAIL rx_err_latvalid got %0d pulses want 0", lat_pulses); else n_pass++;
  endtask

  task automatic test_loopback;
    int n = 0;
    loop_en = 1'b1;
    tx_axis_tready = 1'b1;
    pulse(1'b1, 1'b0);
    while (o_tx_pkt_cnt != 32'd21 && n < 2000) begin @(posedge clk); #1; n++; end
    pulse(1'b0, 1'b1);
    repeat (400) @(posedge clk); #1;
    $display("loopback: tx=%0d rx=%0d err=%0d pulses=%0d", o_tx_pkt_cnt, o_rx_pkt_cnt, o_rx_err_cnt, lat_pulses);
    n_checks++; if (o_tx_pkt_cnt !== 32'd21) $display("FAIL loop_txcnt got %0d want 21", o_tx_pkt_cnt); else n_pass++;
    n_checks++; if (o_rx_pkt_cnt !== 32'd3) $display("FAIL loop_rxcnt got %0d want 3", o_rx_pkt_cnt); else n_pass++;
    n_checks++; if (o_rx_err_cnt !== 32'd3) $display("FAIL loop_errcnt got %0d want 3", o_rx_err_cnt); else n_pass++;
`ifdef SERVER_LATENCY_STAT_EN
    n_checks++; if (lat_pulses !== 3) $display("FAIL loop_pulses got %0d want 3", lat_pulses); else n_pass++;
    n_checks++; if (seen_min !== 64'd100 || seen_max !== 64'd100) $display("FAIL loop_lat_last got %0d..%0d want 100", seen_min, seen_max); else n_pass++;
    n_checks++; if (o_lat_min !== 64'd100 || o_lat_max !== 64'd100) $display("FAIL loop_minmax got %0d/%0d want 100/100", o_lat_min, o_lat_max); else n_pass++;
`else
    n_checks++; if (lat_pulses !== 0) $display("FAIL loop_pulses got %0d want 0", lat_pulses); else n_pass++;
    n_checks++; if (o_lat_min !== 64'hFFFF_FFFF_FFFF_FFFF || o_lat_max !== 64'd0 || o_lat_last !== 64'd0)
      $display("FAIL loop_tied got min=%h max=%h last=%h", o_lat_min, o_lat_max, o_lat_last); else n_pass++;
`endif
    loop_en = 1'b0;
  endtask

  task automatic test_rx_min_frame;
    send_rx_frame(SRC_MAC, 3, 1'b0, 64'd5);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (o_rx_pkt_cnt !== 32'd4) $display("FAIL min_frame_rxcnt got %0d want 4", o_rx_pkt_cnt); else n_pass++;
`ifdef SERVER_LATENCY_STAT_EN
    n_checks++; if (o_lat_last !== 64'd5 || o_lat_min !== 64'd5 || o_lat_max !== 64'd100)
      $display("FAIL min_frame_lat got last=%0d min=%0d max=%0d want 5/5/100", o_lat_last, o_lat_min, o_lat_max); else n_pass++;
`else
    n_checks++; if (o_lat_min !== 64'hFFFF_FFFF_FFFF_FFFF || lat_pulses !== 0)
      $display("FAIL min_frame_tied got min=%h pulses=%0d", o_lat_min, lat_pulses); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_first_frame();
    test_gap();
    test_tor_sequence();
    test_stall();
    test_stop_mid_frame();
    test_same_cycle();
    test_rx_errors();
    test_loopback();
    test_rx_min_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
